// File: rtl/jtag_bridge_pkg.sv
// Shared definitions for the JTAG UART bridge: FSM encoding and the
// JTAG UART register map (DATA/CONTROL addresses and field positions).
package jtag_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_POLL_RX = 2'd1,
    S_POLL_TX = 2'd2,
    S_WRITE   = 2'd3
  } state_e;

  localparam logic ADDR_DATA    = 1'b0;
  localparam logic ADDR_CONTROL = 1'b1;

  localparam int RVALID_BIT = 15;
  localparam int WSPACE_MSB = 31;
  localparam int WSPACE_LSB = 16;

endpackage

// File: rtl/jtag_uart_bridge_if.sv
// Avalon-MM master bus between the bridge and the JTAG UART core.
interface jtag_uart_bridge_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/jtag_uart_bridge_poll_timer.sv
// Idle-cycle counter that flags when a background status poll is due.
module poll_timer #(
  parameter logic [15:0] POLL_INTERVAL = 16'd256
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      cnt_reg <= 16'h0;
    else if (clr)
      cnt_reg <= 16'h0;
    else if (en)
      cnt_reg <= cnt_reg + 16'd1;
  end

  assign expired = en && (cnt_reg == POLL_INTERVAL - 16'd1);

endmodule

// File: rtl/jtag_uart_bridge.sv
// Byte-wide consumer port onto a JTAG UART Avalon slave, with periodic
// RX-data and TX-space polling while idle.
module jtag_uart_bridge
  import jtag_bridge_pkg::*;
#(
  parameter logic [15:0] POLL_INTERVAL = 16'd256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        WE,
  input  logic        Act,
  input  logic [7:0]  Din,
  output logic [7:0]  Dout,
  output logic        R,
  output logic        A,
  jtag_uart_bridge_if.master avm
);

  state_e      state_reg, state_next;
  logic        rx_valid_reg;
  logic [7:0]  rx_byte_reg;
  logic [7:0]  tx_byte_reg;
  logic [15:0] wspace_reg;

  logic act_ok;
  logic accept;
  logic poll_expired;
  logic poll_clr;
  logic unused_rd_bits;

  assign R      = (state_reg == S_IDLE);
  assign A      = WE ? (wspace_reg != 16'h0) : rx_valid_reg;
  assign act_ok = Act && R && A;
  assign accept = !avm.avm_waitrequest;
  assign Dout   = rx_byte_reg;

  // A due poll that finds nothing to do still restarts the interval.
  assign poll_clr = !R || act_ok || poll_expired;

  poll_timer #(.POLL_INTERVAL(POLL_INTERVAL)) u_poll_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (poll_clr),
    .en      (R && !act_ok),
    .expired (poll_expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (act_ok)
          state_next = WE ? S_WRITE : S_POLL_RX;
        else if (poll_expired) begin
          if (!rx_valid_reg)
            state_next = S_POLL_RX;
          else if (wspace_reg == 16'h0)
            state_next = S_POLL_TX;
        end
      end
      S_POLL_RX, S_POLL_TX, S_WRITE: begin
        if (accept)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= S_IDLE;
      rx_valid_reg <= 1'b0;
      rx_byte_reg  <= 8'h0;
      tx_byte_reg  <= 8'h0;
      wspace_reg   <= 16'h0;
    end else begin
      state_reg <= state_next;
      if (act_ok) begin
        if (WE) begin
          tx_byte_reg <= Din;
          wspace_reg  <= wspace_reg - 16'd1;
        end else begin
          rx_valid_reg <= 1'b0;
        end
      end
      if (state_reg == S_POLL_RX && accept && avm.avm_readdata[RVALID_BIT]) begin
        rx_byte_reg  <= avm.avm_readdata[7:0];
        rx_valid_reg <= 1'b1;
      end
      // The latest CONTROL read is authoritative, replacing any local estimate.
      if (state_reg == S_POLL_TX && accept)
        wspace_reg <= avm.avm_readdata[WSPACE_MSB:WSPACE_LSB];
    end
  end

  // Strobes decode straight from state so a reset drops them immediately.
  assign avm.avm_read      = (state_reg == S_POLL_RX) || (state_reg == S_POLL_TX);
  assign avm.avm_write     = (state_reg == S_WRITE);
  assign avm.avm_address   = (state_reg == S_POLL_TX) ? ADDR_CONTROL : ADDR_DATA;
  assign avm.avm_writedata = {24'h0, tx_byte_reg};

  assign unused_rd_bits = ^avm.avm_readdata[14:8];

endmodule

// File: tb/tb_jtag_uart_bridge.sv
// Directed scoreboard bench for jtag_uart_bridge with a small Avalon slave model.
module tb_jtag_uart_bridge;

  logic        Clk;
  logic        Reset;
  logic        WE;
  logic        Act;
  logic [7:0]  Din;
  logic [7:0]  Dout;
  logic        R;
  logic        A;
  logic        waitreq;
  logic [31:0] data_val;
  logic [31:0] ctrl_val;
  logic        stable;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct packed {
    logic        wr;
    logic        addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  jtag_uart_bridge_if bus ();

  assign bus.avm_readdata    = bus.avm_address ? ctrl_val : data_val;
  assign bus.avm_waitrequest = waitreq;

  jtag_uart_bridge #(.POLL_INTERVAL(16'd4)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .WE   (WE),
    .Act  (Act),
    .Din  (Din),
    .Dout (Dout),
    .R    (R),
    .A    (A),
    .avm  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic wr, input logic addr, input logic [31:0] data);
    exp_t e;
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Monitor: every accepted Avalon transfer must match the next expected one.
  always @(negedge Clk) begin
    exp_t e;
    if (bus.avm_read && bus.avm_write) begin
      total_cnt++;
      $display("FAIL strobe_overlap: got read=1 write=1 expected at most one");
    end
    if (Reset && (bus.avm_read || bus.avm_write) && !waitreq) begin
      $display("avalon %s addr=%0d data=%08h", bus.avm_write ? "WR" : "RD",
               bus.avm_address, bus.avm_write ? bus.avm_writedata : bus.avm_readdata);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_xfer: got wr=%0d addr=%0d expected no transfer",
                 bus.avm_write, bus.avm_address);
      end else begin
        e = exp_q.pop_front();
        check("xfer_kind", {31'h0, bus.avm_write}, {31'h0, e.wr});
        check("xfer_addr", {31'h0, bus.avm_address}, {31'h0, e.addr});
        if (e.wr)
          check("xfer_wdata", bus.avm_writedata, e.data);
      end
    end
  end

  initial begin
    Reset    = 1'b0;
    WE       = 1'b0;
    Act      = 1'b0;
    Din      = 8'h0;
    waitreq  = 1'b0;
    data_val = 32'h0001_8041;
    ctrl_val = 32'h0;
    stable   = 1'b1;

    // Reset state
    step(2);
    check("rst_read", bus.avm_read, 0);
    check("rst_write", bus.avm_write, 0);
    check("rst_R", R, 1);
    check("rst_Dout", Dout, 8'h00);
    check("rst_A_rx", A, 0);
    WE = 1'b1;
    #1;
    check("rst_A_tx", A, 0);
    WE = 1'b0;

    // First background RX poll after four idle cycles
    push_exp(1'b0, 1'b0, 32'h0);
    Reset = 1'b1;
    step(3);
    check("pre_poll_read", bus.avm_read, 0);
    check("pre_poll_A", A, 0);
    step(1);
    check("poll_rx_read", bus.avm_read, 1);
    check("poll_rx_addr", bus.avm_address, 0);
    ctrl_val = 32'h0040_0000;
    push_exp(1'b0, 1'b1, 32'h0);
    step(1);
    check("rx_Dout", Dout, 8'h41);
    check("rx_A", A, 1);
    check("rx_R", R, 1);

    // TX-space poll, then a write of 5A
    step(5);
    check("wspace_64", dut.wspace_reg, 16'd64);
    WE = 1'b1;
    #1;
    check("tx_A", A, 1);
    Din = 8'h5A;
    Act = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0000_005A);
    step(1);
    Act = 1'b0;
    check("wr_latency", bus.avm_write, 1);
    check("wr_data_5a", bus.avm_writedata, 32'h0000_005A);
    check("wr_R", R, 0);
    check("wspace_63", dut.wspace_reg, 16'd63);
    step(1);
    check("wr_done_R", R, 1);
    check("wr_done_write", bus.avm_write, 0);

    // Stalled write: strobe and data hold 11 cycles, Act ignored meanwhile
    waitreq = 1'b1;
    Din = 8'hC3;
    Act = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0000_00C3);
    step(1);
    Din = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      if (!bus.avm_write || bus.avm_writedata != 32'h0000_00C3 || R) stable = 1'b0;
      step(1);
    end
    waitreq = 1'b0;
    Act = 1'b0;
    if (!bus.avm_write || bus.avm_writedata != 32'h0000_00C3 || R) stable = 1'b0;
    check("stall_stable", stable, 1);
    step(1);
    check("stall_done_R", R, 1);
    check("stall_wspace", dut.wspace_reg, 16'd62);
    check("stall_txbyte", bus.avm_writedata, 32'h0000_00C3);

    // Consumer read triggers an immediate refetch
    WE = 1'b0;
    data_val = 32'h0000_8037;
    waitreq = 1'b1;
    Act = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0);
    step(1);
    Act = 1'b0;
    check("refetch_read", bus.avm_read, 1);
    check("refetch_addr", bus.avm_address, 0);
    check("refetch_A", A, 0);
    step(1);
    check("refetch_hold_A", A, 0);
    check("refetch_hold_Dout", Dout, 8'h41);
    waitreq = 1'b0;
    step(1);
    check("refetch_Dout", Dout, 8'h37);
    check("refetch_A1", A, 1);

    // Reset during a stalled read abandons it
    waitreq = 1'b1;
    Act = 1'b1;
    step(1);
    Act = 1'b0;
    check("abort_read_on", bus.avm_read, 1);
    #2;
    Reset = 1'b0;
    #1;
    check("abort_read_off", bus.avm_read, 0);
    check("abort_write_off", bus.avm_write, 0);
    check("abort_R", R, 1);
    check("abort_Dout", Dout, 8'h00);
    check("abort_rx_valid", dut.rx_valid_reg, 0);
    check("abort_wspace", dut.wspace_reg, 16'h0);
    check("abort_txbyte", bus.avm_writedata, 32'h0);
    waitreq  = 1'b0;
    data_val = 32'h0000_8099;
    ctrl_val = 32'h0001_0000;
    step(2);
    push_exp(1'b0, 1'b0, 32'h0);
    push_exp(1'b0, 1'b1, 32'h0);
    Reset = 1'b1;
    step(10);
    check("rerun_Dout", Dout, 8'h99);
    check("rerun_wspace", dut.wspace_reg, 16'd1);

    // wspace=1: only the first of two writes goes out
    WE = 1'b1;
    Din = 8'h11;
    Act = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0000_0011);
    step(1);
    Act = 1'b0;
    check("ws1_write", bus.avm_write, 1);
    check("ws1_data", bus.avm_writedata, 32'h0000_0011);
    step(1);
    check("ws1_R", R, 1);
    check("ws1_A", A, 0);
    Din = 8'h22;
    Act = 1'b1;
    ctrl_val = 32'h0002_0000;
    push_exp(1'b0, 1'b1, 32'h0);
    step(1);
    Act = 1'b0;
    check("ws0_no_write", bus.avm_write, 0);
    check("ws0_R", R, 1);
    check("ws0_txbyte", bus.avm_writedata, 32'h0000_0011);
    step(5);
    check("ws_repoll", dut.wspace_reg, 16'd2);
    check("queue_drained", exp_q.size(), 0);
    step(4);
    check("queue_final", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/jtag_uart_bridge.md
JTAG_UART_BRIDGE -- requirements
Module: jtag_uart_bridge

Interface
REQ-001 Parameter POLL_INTERVAL, default 16'd256: idle cycles between background status polls; legal values 1 to 65535.
REQ-002 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 WE  input  1  transfer direction: 0 = byte from JTAG to the consumer, 1 = byte from the consumer to JTAG.
REQ-005 Act  input  1  single-cycle transfer strobe; honoured only when R and A are both 1 in the same cycle.
REQ-006 Din  input  8  byte to transmit; sampled in the cycle Act is honoured with WE=1.
REQ-007 Dout  output  8  held received byte; valid whenever A=1 and WE=0.
REQ-008 R  output  1  bridge ready; asserted in state S_IDLE.
REQ-009 A  output  1  combinational: rx_valid when WE=0, (wspace != 0) when WE=1.
REQ-010 avm_address  output  1  Avalon word address: 0 = DATA register, 1 = CONTROL register.
REQ-011 avm_read, avm_write  output  1 each  Avalon strobes; held until avm_waitrequest=0.
REQ-012 avm_writedata  output  32  Avalon write data, {24'h0, tx byte}.
REQ-013 avm_readdata  input  32  Avalon read data; valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-014 avm_waitrequest  input  1  Avalon stall.

Function
REQ-015 FSM states: S_IDLE, S_POLL_RX, S_POLL_TX, S_WRITE.
REQ-016 S_POLL_RX: avm_read=1, avm_address=0; on accept: if readdata[15] (RVALID)=1, then rx_byte <= readdata[7:0] and rx_valid <= 1; next state S_IDLE.
REQ-017 S_POLL_TX: avm_read=1, avm_address=1; on accept: wspace <= readdata[31:16]; next state S_IDLE.
REQ-018 S_WRITE: avm_write=1, avm_address=0, avm_writedata={24'h0, tx_byte}; on accept: next state S_IDLE.
REQ-019 In S_IDLE with Act=1, WE=1, wspace!=0: tx_byte <= Din; wspace <= wspace-1; next state S_WRITE.
REQ-020 In S_IDLE with Act=1, WE=0, rx_valid=1: rx_valid <= 0; next state S_POLL_RX, an immediate refetch.
REQ-021 Act while R=0 or A=0 is ignored; it causes no state change and no counter change.
REQ-022 poll_cnt (16 bit) increments each cycle in S_IDLE when no Act is honoured; it clears on leaving S_IDLE.
REQ-023 When poll_cnt reaches POLL_INTERVAL-1 and no Act is honoured:
- rx_valid=0: go to S_POLL_RX.
- rx_valid=1 and wspace=0: go to S_POLL_TX.
- otherwise: poll_cnt clears and the bridge stays in S_IDLE.
REQ-024 An honoured Act always takes priority over a poll expiry in the same cycle.
REQ-025 wspace never underflows: a decrement happens only when wspace!=0; a POLL_TX result overwrites any previous value.
REQ-026 Transfer latency: honoured Act to the Avalon strobe asserted is 1 cycle; R returns to 1 in the cycle after Avalon accept.
REQ-027 Dout and rx_byte are stable from capture until the next POLL_RX capture with RVALID=1.
REQ-028 In every state other than the one named above, avm_read and avm_write are 0; the two strobes are never asserted together.

Reset
REQ-029 Reset low forces: state S_IDLE, rx_valid=0, rx_byte=8'h0, tx_byte=8'h0, wspace=16'h0, poll_cnt=0.
REQ-030 Reset asserted mid-Avalon transfer drops avm_read/avm_write immediately; the in-flight transfer is abandoned without retry.
REQ-031 After reset release the first POLL_RX starts after POLL_INTERVAL cycles; A=0 in both directions until then.

Structure
REQ-032 Shared package jtag_bridge_pkg holds:
- the state enum;
- the DATA/CONTROL address constants;
- the RVALID bit index (15);
- the WSPACE field bounds (31:16).
REQ-033 Sub-module poll_timer, a 16-bit counter with clear, enable and expiry compare against POLL_INTERVAL, is instantiated once.
REQ-034 Target size is 120-400 lines of RTL; no other hierarchy.

Verification
REQ-035 Reset, POLL_INTERVAL=4, readdata=32'h0001_8041 -> after 4 idle cycles one POLL_RX read; rx_valid=1, Dout=8'h41, A=1 with WE=0.
REQ-036 WE=0, Act pulse with rx_valid=1 -> next cycle avm_read=1, avm_address=0; rx_valid=0 until the new RVALID read.
REQ-037 rx_valid=1, wspace=0, CONTROL readdata=32'h0040_0000 -> wspace=64; WE=1, Act, Din=8'h5A -> avm_write with avm_writedata=32'h0000_005A, wspace=63.
REQ-038 wspace=1: two Act pulses spaced after R returns -> exactly one avm_write; the second Act is ignored and A=0.
REQ-039 avm_waitrequest held high 10 cycles during S_WRITE -> avm_write and avm_writedata stable 11 cycles; R=0 throughout; Act ignored.
REQ-040 Reset dropped low while avm_read=1 -> avm_read=0 in the same cycle; all registers at reset values; no spurious write after release.
